// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives the combinational instruction
// memory and buffers {pc, word} pairs in a small queue drained over valid/ready.
// Optional build macro FETCH_PERF_EN adds saturating fetch/stall counter ports.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] LAST_PC  = 32'h0000_0014,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        misalign
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  // QDEPTH is 2 or 4, so pointers wrap naturally at a power of two.
  localparam int unsigned PtrW = (QDEPTH > 2) ? 2 : 1;
  localparam logic [PtrW:0] QFull = (PtrW + 1)'(QDEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [31:0]       r_pc;
  logic [31:0]       w_pc_d;
  logic [31:0]       r_q_instr [QDEPTH];
  logic [31:0]       r_q_pc    [QDEPTH];
  logic [PtrW-1:0]   r_rd_ptr;
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW:0]     r_count;
  logic [31:0]       r_hold_instr;
  logic [31:0]       r_hold_pc;
  logic              r_misalign;
  logic              w_push;
  logic              w_pop;

  // Redirect outranks both queue operations; a pop coinciding with it is dropped.
  always_comb begin
    w_pop  = out_valid & out_ready & ~redirect_valid;
    w_push = (r_state == StRun) & ~redirect_valid & ((r_count != QFull) | w_pop);
  end

  // Next-state and next-PC selection.
  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    unique case (r_state)
      StIdle:  if (start) w_state_d = StRun;
      StRun:   if (w_push && (r_pc == LAST_PC)) w_state_d = StHalt;
      StHalt:  w_state_d = StHalt;
      default: w_state_d = StIdle;
    endcase
    if (redirect_valid) begin
      w_pc_d = {redirect_pc[31:2], 2'b00};
      // A redirect revives a halted run but never starts an idle one.
      if (r_state == StHalt) w_state_d = StRun;
      else if (r_state == StIdle) w_state_d = StIdle;
    end else if (w_push && (r_pc != LAST_PC)) begin
      w_pc_d = r_pc + 32'd4;
    end
  end

  // State, PC and misalign pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_misalign <= redirect_valid & (redirect_pc[1:0] != 2'b00);
    end
  end

  // Fetch queue storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        r_q_instr[i] <= 32'h0;
        r_q_pc[i]    <= 32'h0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_q_instr[r_wr_ptr] <= imem_rdata;
        r_q_pc[r_wr_ptr]    <= r_pc;
        r_wr_ptr            <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop) r_count <= r_count + (PtrW + 1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (PtrW + 1)'(1);
    end
  end

  // Remember the last presented head so outputs hold while the queue is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_instr <= 32'h0;
      r_hold_pc    <= 32'h0;
    end else if (out_valid) begin
      r_hold_instr <= r_q_instr[r_rd_ptr];
      r_hold_pc    <= r_q_pc[r_rd_ptr];
    end
  end

  // Output drive.
  always_comb begin
    imem_addr = r_pc;
    out_valid = (r_count != '0);
    out_instr = out_valid ? r_q_instr[r_rd_ptr] : r_hold_instr;
    out_pc    = out_valid ? r_q_pc[r_rd_ptr] : r_hold_pc;
    halted    = (r_state == StHalt);
    misalign  = r_misalign;
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= 32'h0;
      r_stall_cnt <= 32'h0;
    end else begin
      if (w_push && (r_fetch_cnt != 32'hFFFF_FFFF)) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if ((r_state == StRun) && !w_push && !redirect_valid &&
          (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  // Counter outputs.
  always_comb begin
    fetch_cnt = r_fetch_cnt;
    stall_cnt = r_stall_cnt;
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; memory holds 10..60 at 0..20.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic        misalign;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted),
    .misalign       (misalign)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program memory: word n at address 4n holds 10*(n+1) for n = 0..5.
  always_comb begin
    if ((imem_addr <= 32'd20) && (imem_addr[1:0] == 2'b00)) begin
      imem_rdata = ((imem_addr >> 2) + 32'd1) * 32'd10;
    end else begin
      imem_rdata = 32'hDEAD_BEEF;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;

    // Reset values.
    do_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);

    // Full program streams out with ready held high.
    out_ready = 1'b1;
    pulse_start();
    check("s1_lat_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("s1_valid", 32'(out_valid), 32'd1);
      check("s1_instr", out_instr, 32'(10 * (i + 1)));
      check("s1_pc", out_pc, 32'(4 * i));
      check("s1_halted", 32'(halted), (i == 5) ? 32'd1 : 32'd0);
    end
    tick();
    check("s1_drained", 32'(out_valid), 32'd0);
    check("s1_hold_instr", out_instr, 32'd60);
    check("s1_hold_pc", out_pc, 32'd20);
    check("s1_halted_end", 32'(halted), 32'd1);
`ifdef FETCH_PERF_EN
    check("s1_fetch_cnt", fetch_cnt, 32'd6);
    check("s1_stall_cnt", stall_cnt, 32'd0);
`endif

    // Backpressure: queue fills to two, PC stalls at 8, then drains in order.
    do_reset();
    out_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 4; i++) tick();
    check("s2_valid", 32'(out_valid), 32'd1);
    check("s2_head", out_instr, 32'd10);
    check("s2_head_pc", out_pc, 32'd0);
    check("s2_addr", imem_addr, 32'd8);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s2_instr", out_instr, 32'(20 + 10 * i));
      check("s2_pc", out_pc, 32'(4 + 4 * i));
    end

    // Redirect to 12 flushes {10,20} even though ready is high.
    do_reset();
    out_ready = 1'b0;
    pulse_start();
    tick();
    tick();
    check("s3_addr_pre", imem_addr, 32'd8);
    check("s3_head_pre", out_instr, 32'd10);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'd12;
    tick();
    redirect_valid = 1'b0;
    check("s3_flush_valid", 32'(out_valid), 32'd0);
    check("s3_addr", imem_addr, 32'd12);
    check("s3_misalign", 32'(misalign), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s3_valid", 32'(out_valid), 32'd1);
      check("s3_instr", out_instr, 32'(40 + 10 * i));
      check("s3_pc", out_pc, 32'(12 + 4 * i));
    end
    check("s3_halted", 32'(halted), 32'd1);
    tick();
    check("s3_empty", 32'(out_valid), 32'd0);

    // Redirect out of HALT resumes fetching at 4.
    redirect_valid = 1'b1;
    redirect_pc    = 32'd4;
    tick();
    redirect_valid = 1'b0;
    check("s4_unhalt", 32'(halted), 32'd0);
    check("s4_valid", 32'(out_valid), 32'd0);
    check("s4_addr", imem_addr, 32'd4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s4_instr", out_instr, 32'(20 + 10 * i));
      check("s4_pc", out_pc, 32'(4 + 4 * i));
    end
    check("s4_rehalt", 32'(halted), 32'd1);

    // Misaligned redirect target is truncated and flagged for one cycle.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0009;
    tick();
    redirect_valid = 1'b0;
    check("s5_misalign_hi", 32'(misalign), 32'd1);
    check("s5_addr", imem_addr, 32'd8);
    check("s5_halted", 32'(halted), 32'd0);
    check("s5_flush", 32'(out_valid), 32'd0);
    tick();
    check("s5_misalign_lo", 32'(misalign), 32'd0);
    check("s5_instr", out_instr, 32'd30);
    check("s5_pc", out_pc, 32'd8);
    tick();
    check("s5_next", out_instr, 32'd40);

    // Asynchronous reset between edges while running.
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_valid", 32'(out_valid), 32'd0);
    check("s6_instr", out_instr, 32'd0);
    check("s6_pc", out_pc, 32'd0);
    check("s6_addr", imem_addr, 32'd0);
    check("s6_halted", 32'(halted), 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    check("s6_idle", 32'(out_valid), 32'd0);
    pulse_start();
    tick();
    check("s6_restart_instr", out_instr, 32'd10);
    check("s6_restart_pc", out_pc, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that sequences the combinational instruction memory. It owns the program counter and drives the memory address. Each returned word is captured with its PC into a small fetch queue, which the decode stage drains over a valid/ready handshake. Branch redirects, start and halt-at-end-of-program are handled here.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
LAST_PC, 32'h0000_0014, address of the final program word; fetching it ends the run.
QDEPTH, 2, fetch-queue entries; legal values 2 or 4.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; leaves IDLE and begins fetching.
imem_addr  out  32  address to instruction memory; always equals pc.
imem_rdata  in  32  instruction word from memory, valid in the same cycle as imem_addr.
redirect_valid  in  1  branch/jump redirect request.
redirect_pc  in  32  redirect target.
out_valid  out  1  queue head valid.
out_ready  in  1  decode accepts head.
out_instr  out  32  head instruction.
out_pc  out  32  PC of head instruction.
halted  out  1  high once LAST_PC has been fetched.
misalign  out  1  one-cycle pulse when redirect_pc[1:0] != 0.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, queue empty, out_valid=0, out_instr=0, out_pc=0, halted=0, misalign=0.
- States are IDLE, RUN and HALT.
- IDLE: no queue writes. A start pulse moves to RUN the next cycle. start in RUN or HALT is ignored.
- RUN, enqueue condition: enqueue {pc, imem_rdata} when count<QDEPTH, or when count==QDEPTH and a pop (out_valid&out_ready) occurs in the same cycle.
- RUN, on enqueue: pc <= pc+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- RUN, end of program: if the enqueued pc==LAST_PC, pc holds, state goes to HALT and halted goes to 1 the next cycle.
- RUN, stall: with no enqueue, pc holds.
- HALT: no queue writes; the queue keeps draining normally.
- Pop: out_valid=(count!=0), with out_instr/out_pc taken from the queue head. A pop removes the head on the rising edge. Push and pop in the same cycle leave count unchanged. out_instr/out_pc hold their last value when empty; they do not return to 0.
- Redirect: redirect_valid has top priority over push and pop.
  - Queue is flushed (count=0, out_valid=0 next cycle); a simultaneous pop is discarded.
  - pc <= {redirect_pc[31:2], 2'b00}, with no enqueue that cycle.
  - misalign pulses high for one cycle if redirect_pc[1:0]!=0.
  - From HALT: state goes to RUN and halted clears.
  - From IDLE: pc updates but state stays IDLE.
- Latency: the first word is visible on out_valid 2 cycles after the start pulse (1 cycle IDLE→RUN, 1 cycle enqueue). Steady-state throughput is 1 word/cycle while out_ready=1.
- Reset mid-run: all state clears immediately (asynchronous), with no partial queue contents retained.

Optional Feature:
FETCH_PERF_EN
- Defined: adds output ports fetch_cnt[31:0] and stall_cnt[31:0].
  - fetch_cnt counts enqueues.
  - stall_cnt counts RUN cycles with no enqueue and no redirect.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: neither the ports nor the counters exist.

Test Plan:
- Memory holds 10,20,30,40,50,60 at addresses 0,4,…,20; defaults, start at cycle 1, out_ready=1 → out_instr 10..60 with out_pc 0..20 on consecutive cycles; halted=1 after the pc=20 fetch; out_valid=0 afterwards.
- Same setup with out_ready=0 for 5 cycles after start → count reaches 2, pc holds at 8, imem_addr=8. Release ready → 10,20,30 are delivered in order with no loss or duplication.
- Redirect_pc=12 asserted while the queue holds {0:10, 4:20} and out_ready=1 → next out_valid=0; the following word is 40 with out_pc=12; 10/20 are never delivered after the flush.
- In HALT, redirect_pc=4 → halted drops, fetch resumes 20,30,40,50,60, then HALT again.
- Redirect_pc=32'h0000_0009 → misalign=1 for exactly one cycle; next fetch is from pc=8 (word 30).
- Assert rst_n=0 between clock edges while running → outputs go to reset values without waiting for a clock; a fresh start restarts at RESET_PC. With FETCH_PERF_EN defined, the first scenario ends with fetch_cnt=6.
